// File: rtl/imm_gen_pipe_if.sv
// rtl/imm_gen_pipe_if.sv - instruction-in / immediate-out handshake bundle for imm_gen_pipe
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int FMT_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [FMT_W-1:0] out_fmt;
  logic             out_illegal;

  // master: the fetch/decode side that supplies instructions and consumes immediates
  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined RISC-V immediate generator with 2-entry skid buffer
// Optional IMM_GEN_CSR_EN: CSR immediate forms (funct3[2]=1) decode as Z format.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int FMT_W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  imm_gen_pipe_if.slave bus
);

  localparam logic [FMT_W-1:0] FMT_NONE = FMT_W'(0);
  localparam logic [FMT_W-1:0] FMT_I    = FMT_W'(1);
  localparam logic [FMT_W-1:0] FMT_S    = FMT_W'(2);
  localparam logic [FMT_W-1:0] FMT_B    = FMT_W'(3);
  localparam logic [FMT_W-1:0] FMT_U    = FMT_W'(4);
  localparam logic [FMT_W-1:0] FMT_J    = FMT_W'(5);
`ifdef IMM_GEN_CSR_EN
  localparam logic [FMT_W-1:0] FMT_Z    = FMT_W'(6);
`endif

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [FMT_W-1:0] fmt;
    logic             ill;
  } entry_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  logic [31:0] instr;
  entry_t      dec;
  entry_t      main_q;
  entry_t      skid_q;
  occ_e        occ_q;
  occ_e        occ_d;
  logic        accept;
  logic        drain;
  logic        load_main_new;
  logic        load_main_skid;
  logic        load_skid;

  assign instr = bus.in_instr;

  // Size casts of signed fields sign-extend, so each format needs no explicit replication.
  always_comb begin
    dec.imm = '0;
    dec.fmt = FMT_NONE;
    dec.ill = 1'b0;
    case (instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: begin
        dec.fmt = FMT_I;
        dec.imm = XLEN'($signed(instr[31:20]));
      end
      7'b1110011: begin
`ifdef IMM_GEN_CSR_EN
        if (instr[14]) begin
          dec.fmt = FMT_Z;
          dec.imm = XLEN'(instr[19:15]);
        end else begin
          dec.fmt = FMT_I;
          dec.imm = XLEN'($signed(instr[31:20]));
        end
`else
        dec.fmt = FMT_I;
        dec.imm = XLEN'($signed(instr[31:20]));
`endif
      end
      7'b0100011: begin
        dec.fmt = FMT_S;
        dec.imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      end
      7'b1100011: begin
        dec.fmt = FMT_B;
        dec.imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      end
      7'b0110111, 7'b0010111: begin
        dec.fmt = FMT_U;
        dec.imm = XLEN'($signed({instr[31:12], 12'b0}));
      end
      7'b1101111: begin
        dec.fmt = FMT_J;
        dec.imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      end
      7'b0110011: begin
        dec.fmt = FMT_NONE;
      end
      default: begin
        dec.ill = 1'b1;
      end
    endcase
  end

  // in_ready depends only on registered occupancy, never on out_ready.
  assign accept = bus.in_valid && (occ_q != OCC_FULL);
  assign drain  = (occ_q != OCC_EMPTY) && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= OCC_EMPTY;
    end else begin
      occ_q <= occ_d;
    end
  end

  always_comb begin
    occ_d          = occ_q;
    load_main_new  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (occ_q)
      OCC_EMPTY: begin
        if (accept) begin
          load_main_new = 1'b1;
          occ_d         = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (accept && drain) begin
          load_main_new = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          occ_d     = OCC_FULL;
        end else if (drain) begin
          occ_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (drain) begin
          load_main_skid = 1'b1;
          occ_d          = OCC_ONE;
        end
      end
      default: begin
        occ_d = OCC_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_new) begin
        main_q <= dec;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= dec;
      end
    end
  end

  assign bus.in_ready    = (occ_q != OCC_FULL);
  assign bus.out_valid   = (occ_q != OCC_EMPTY);
  assign bus.out_imm     = main_q.imm;
  assign bus.out_fmt     = main_q.fmt;
  assign bus.out_illegal = main_q.ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed self-checking bench for imm_gen_pipe (XLEN 32 and 64)
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  imm_gen_pipe_if #(.XLEN(32), .FMT_W(3)) b32 ();
  imm_gen_pipe_if #(.XLEN(64), .FMT_W(3)) b64 ();

  imm_gen_pipe #(.XLEN(32), .FMT_W(3)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  imm_gen_pipe #(.XLEN(64), .FMT_W(3)) u_dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));

  assign b64.in_valid  = b32.in_valid;
  assign b64.in_instr  = b32.in_instr;
  assign b64.out_ready = b32.out_ready;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_check(input string tag, input logic [31:0] ins, input logic [63:0] e32,
                            input logic [63:0] e64, input logic [2:0] efmt, input logic eill);
    b32.in_valid  = 1'b1;
    b32.in_instr  = ins;
    b32.out_ready = 1'b1;
    step();
    check({tag, ".valid"}, 64'(b32.out_valid), 64'd1);
    check({tag, ".imm32"}, 64'(b32.out_imm), e32);
    check({tag, ".imm64"}, b64.out_imm, e64);
    check({tag, ".fmt"}, 64'(b32.out_fmt), 64'(efmt));
    check({tag, ".ill"}, 64'(b32.out_illegal), 64'(eill));
  endtask

  function automatic logic [31:0] addi_imm(input int v);
    logic [11:0] f;
    f = 12'(v);
    return {f, 5'd0, 3'd0, 5'd1, 7'h13};
  endfunction

  initial begin
    int sent;
    int recv;
    logic prev_stall;
    logic [31:0] prev_imm;

    b32.in_valid  = 1'b0;
    b32.in_instr  = 32'h0;
    b32.out_ready = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    check("rst.valid", 64'(b32.out_valid), 64'd0);
    check("rst.ready", 64'(b32.in_ready), 64'd1);
    check("rst.imm", 64'(b32.out_imm), 64'd0);
    check("rst.fmt", 64'(b32.out_fmt), 64'd0);
    check("rst.ill", 64'(b32.out_illegal), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    send_check("addi", 32'hFFF00093, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
    send_check("beq",  32'hFE000EE3, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0);
    send_check("lui",  32'h800000B7, 64'h80000000, 64'hFFFFFFFF80000000, 3'd4, 1'b0);
    send_check("sw",   32'hFE112E23, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0);
    send_check("jalp", 32'h008000EF, 64'h8, 64'h8, 3'd5, 1'b0);
    send_check("jaln", 32'hFFDFF06F, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd5, 1'b0);
    send_check("rtype", 32'h002081B3, 64'h0, 64'h0, 3'd0, 1'b0);
    send_check("illeg", 32'h0000007F, 64'h0, 64'h0, 3'd0, 1'b1);
`ifdef IMM_GEN_CSR_EN
    send_check("csrrwi", 32'h300FD0F3, 64'd31, 64'd31, 3'd6, 1'b0);
`else
    send_check("csrrwi", 32'h300FD0F3, 64'h300, 64'h300, 3'd1, 1'b0);
`endif
    send_check("csrrw", 32'h300090F3, 64'h300, 64'h300, 3'd1, 1'b0);

    b32.in_valid = 1'b0;
    step();
    check("idle.valid", 64'(b32.out_valid), 64'd0);

    // Stall with four queued items: only two fit, order must survive the release.
    b32.out_ready = 1'b0;
    b32.in_valid  = 1'b1;
    b32.in_instr  = addi_imm(1);
    step();
    check("st1.imm", 64'(b32.out_imm), 64'd1);
    check("st1.rdy", 64'(b32.in_ready), 64'd1);
    b32.in_instr = addi_imm(2);
    step();
    check("st2.imm", 64'(b32.out_imm), 64'd1);
    check("st2.rdy", 64'(b32.in_ready), 64'd0);
    b32.in_instr = addi_imm(3);
    step();
    check("st3.imm", 64'(b32.out_imm), 64'd1);
    check("st3.rdy", 64'(b32.in_ready), 64'd0);
    check("st3.valid", 64'(b32.out_valid), 64'd1);
    b32.out_ready = 1'b1;
    step();
    check("rel1.imm", 64'(b32.out_imm), 64'd2);
    check("rel1.rdy", 64'(b32.in_ready), 64'd1);
    step();
    check("rel2.imm", 64'(b32.out_imm), 64'd3);
    b32.in_instr = addi_imm(4);
    step();
    check("rel3.imm", 64'(b32.out_imm), 64'd4);
    b32.in_valid = 1'b0;
    step();
    check("rel4.valid", 64'(b32.out_valid), 64'd0);

    // Asynchronous reset while full must discard both entries immediately.
    b32.out_ready = 1'b0;
    b32.in_valid  = 1'b1;
    b32.in_instr  = addi_imm(9);
    step();
    b32.in_instr = addi_imm(10);
    step();
    b32.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mrst.valid", 64'(b32.out_valid), 64'd0);
    check("mrst.ready", 64'(b32.in_ready), 64'd1);
    check("mrst.imm", 64'(b32.out_imm), 64'd0);
    check("mrst.fmt", 64'(b32.out_fmt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("mrst.empty", 64'(b32.out_valid), 64'd0);
    b32.in_valid  = 1'b1;
    b32.out_ready = 1'b1;
    b32.in_instr  = addi_imm(5);
    step();
    check("mrst.new", 64'(b32.out_imm), 64'd5);
    b32.in_valid = 1'b0;
    step();

    // Random valid/ready toggling against an in-order counter model.
    sent = 0;
    recv = 0;
    prev_stall = 1'b0;
    prev_imm = '0;
    for (int i = 0; i < 400; i++) begin
      if (prev_stall) begin
        check("hold.valid", 64'(b32.out_valid), 64'd1);
        check("hold.imm", 64'(b32.out_imm), 64'(prev_imm));
      end
      b32.in_valid  = 1'($urandom_range(0, 1));
      b32.out_ready = 1'($urandom_range(0, 1));
      b32.in_instr  = addi_imm(sent);
      #1;
      if (b32.out_valid && b32.out_ready) begin
        check("rnd.imm32", 64'(b32.out_imm), 64'(recv));
        check("rnd.imm64", b64.out_imm, 64'(recv));
        recv++;
      end
      if (b32.in_valid && b32.in_ready) sent++;
      prev_stall = b32.out_valid && !b32.out_ready;
      prev_imm   = b32.out_imm;
      step();
    end
    b32.in_valid  = 1'b0;
    b32.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (b32.out_valid) begin
        check("drn.imm", 64'(b32.out_imm), 64'(recv));
        recv++;
      end
      step();
    end
    check("rnd.count", 64'(recv), 64'(sent));
    check("rnd.empty", 64'(b32.out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
